// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame controller.
// The FSM state, decoded command class and the protocol byte values live here.
package uart_pkg;

    localparam int CLKS_PER_BIT = 868;
    // Two 10-bit byte times at the nominal bit rate.
    localparam int TIMEOUT_DEF  = 20 * CLKS_PER_BIT;

    localparam logic [7:0] OPC_WR  = 8'h01;
    localparam logic [7:0] OPC_RD  = 8'h02;
    localparam logic [7:0] OPC_LED = 8'h03;

    localparam logic [7:0] SYNC_DEF = 8'hA5;
    localparam logic [7:0] RSP_DEF  = 8'h5A;
    localparam logic [7:0] ACK_DEF  = 8'h06;
    localparam logic [7:0] NAK_DEF  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_OPC,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_TX_0,
        ST_TX_1,
        ST_TX_2,
        ST_TX_3
    } state_t;

    typedef enum logic [1:0] {
        CMD_WR,
        CMD_RD,
        CMD_LED,
        CMD_BAD
    } cmd_t;

    // A frame is bad if its checksum fails or its opcode is not recognised.
    function automatic cmd_t classify_cmd(input logic [7:0] opc,
                                          input logic [7:0] addr,
                                          input logic [7:0] data,
                                          input logic [7:0] chk);
        cmd_t cmd;
        if ((opc ^ addr ^ data) != chk) begin
            cmd = CMD_BAD;
        end else begin
            case (opc)
                OPC_WR:  cmd = CMD_WR;
                OPC_RD:  cmd = CMD_RD;
                OPC_LED: cmd = CMD_LED;
                default: cmd = CMD_BAD;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry once LIMIT idle cycles have elapsed.
module uart_cmd_timeout
    import uart_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Saturates at LIMIT so a stalled owner never sees the counter wrap.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != LIMIT_W)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = enable && (count_reg == LIMIT_W);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: assembles SYNC/OPC/ADDR/DATA/CHK frames from the
// UART receiver, executes write/read/LED commands and streams the reply bytes.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = TIMEOUT_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEF,
    parameter logic [7:0] RSP_BYTE     = RSP_DEF,
    parameter logic [7:0] ACK_BYTE     = ACK_DEF,
    parameter logic [7:0] NAK_BYTE     = NAK_DEF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_datav_in,
    input  logic [7:0] rx_byte_in,
    output logic       wr_en_op,
    output logic       rd_en_op,
    output logic [7:0] addr_op,
    output logic [7:0] wr_data_op,
    input  logic [7:0] rd_data_in,
    output logic       tx_valid_op,
    output logic [7:0] tx_byte_op,
    input  logic       tx_ready_in,
    output logic       led_op,
    output logic       err_timeout_op,
    output logic       err_overrun_op
);

    state_t     state_reg, state_next;
    cmd_t       cmd_reg, cmd_new;
    logic [7:0] opc_reg, addr_reg, data_reg;
    logic [7:0] addr_out_reg, wr_data_reg, rd_data_reg;
    logic       led_reg;

    logic       in_get;
    logic       to_clear, to_enable, to_expired;
    logic [7:0] first_byte;

    logic       tx_valid_c, wr_en_c, rd_en_c, err_timeout_c, err_overrun_c;
    logic [7:0] tx_byte_c;

    uart_cmd_timeout #(
        .LIMIT (TIMEOUT_CLKS)
    ) u_timeout (
        .clk     (clk_in),
        .srst    (rst_in),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    assign in_get    = state_reg inside {ST_GET_OPC, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK};
    assign to_clear  = rx_datav_in || (state_reg == ST_IDLE);
    assign to_enable = in_get;

    always_comb cmd_new = classify_cmd(opc_reg, addr_reg, data_reg, rx_byte_in);

    always_comb begin
        if (cmd_reg == CMD_RD) begin
            first_byte = RSP_BYTE;
        end else if (cmd_reg == CMD_BAD) begin
            first_byte = NAK_BYTE;
        end else begin
            first_byte = ACK_BYTE;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_valid_c    = 1'b0;
        tx_byte_c     = 8'h00;
        wr_en_c       = 1'b0;
        rd_en_c       = 1'b0;
        err_timeout_c = 1'b0;
        err_overrun_c = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_datav_in && (rx_byte_in == SYNC_BYTE)) begin
                    state_next = ST_GET_OPC;
                end
            end
            ST_GET_OPC, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
                // An arriving byte takes priority over an expiring counter.
                if (rx_datav_in) begin
                    case (state_reg)
                        ST_GET_OPC:  state_next = ST_GET_ADDR;
                        ST_GET_ADDR: state_next = ST_GET_DATA;
                        ST_GET_DATA: state_next = ST_GET_CHK;
                        default:     state_next = ST_EXEC;
                    endcase
                end else if (to_expired) begin
                    err_timeout_c = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                err_overrun_c = rx_datav_in;
                if (cmd_reg == CMD_RD) begin
                    rd_en_c    = 1'b1;
                    state_next = ST_RD_WAIT;
                end else begin
                    // ACK/NAK is offered straight away to keep reply latency at one cycle.
                    wr_en_c    = (cmd_reg == CMD_WR);
                    tx_valid_c = 1'b1;
                    tx_byte_c  = first_byte;
                    state_next = tx_ready_in ? ST_IDLE : ST_TX_0;
                end
            end
            ST_RD_WAIT: begin
                err_overrun_c = rx_datav_in;
                tx_valid_c    = 1'b1;
                tx_byte_c     = RSP_BYTE;
                state_next    = tx_ready_in ? ST_TX_1 : ST_TX_0;
            end
            ST_TX_0: begin
                err_overrun_c = rx_datav_in;
                tx_valid_c    = 1'b1;
                tx_byte_c     = first_byte;
                if (tx_ready_in) begin
                    state_next = (cmd_reg == CMD_RD) ? ST_TX_1 : ST_IDLE;
                end
            end
            ST_TX_1: begin
                err_overrun_c = rx_datav_in;
                tx_valid_c    = 1'b1;
                tx_byte_c     = addr_out_reg;
                if (tx_ready_in) state_next = ST_TX_2;
            end
            ST_TX_2: begin
                err_overrun_c = rx_datav_in;
                tx_valid_c    = 1'b1;
                tx_byte_c     = rd_data_reg;
                if (tx_ready_in) state_next = ST_TX_3;
            end
            ST_TX_3: begin
                err_overrun_c = rx_datav_in;
                tx_valid_c    = 1'b1;
                tx_byte_c     = addr_out_reg ^ rd_data_reg;
                if (tx_ready_in) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= CMD_BAD;
            opc_reg      <= 8'h00;
            addr_reg     <= 8'h00;
            data_reg     <= 8'h00;
            addr_out_reg <= 8'h00;
            wr_data_reg  <= 8'h00;
            rd_data_reg  <= 8'h00;
            led_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (rx_datav_in) begin
                case (state_reg)
                    ST_GET_OPC:  opc_reg  <= rx_byte_in;
                    ST_GET_ADDR: addr_reg <= rx_byte_in;
                    ST_GET_DATA: data_reg <= rx_byte_in;
                    ST_GET_CHK: begin
                        cmd_reg <= cmd_new;
                        // Bus address/data only move for accepted commands.
                        if (cmd_new == CMD_WR) begin
                            addr_out_reg <= addr_reg;
                            wr_data_reg  <= data_reg;
                        end else if (cmd_new == CMD_RD) begin
                            addr_out_reg <= addr_reg;
                        end
                    end
                    default: ;
                endcase
            end
            if ((state_reg == ST_EXEC) && (cmd_reg == CMD_LED)) begin
                led_reg <= data_reg[0];
            end
            if (state_reg == ST_RD_WAIT) begin
                rd_data_reg <= rd_data_in;
            end
        end
    end

    // Strobes are masked while reset is asserted so a reply dies immediately.
    assign tx_valid_op    = tx_valid_c & ~rst_in;
    assign tx_byte_op     = rst_in ? 8'h00 : tx_byte_c;
    assign wr_en_op       = wr_en_c & ~rst_in;
    assign rd_en_op       = rd_en_c & ~rst_in;
    assign err_timeout_op = err_timeout_c & ~rst_in;
    assign err_overrun_op = err_overrun_c & ~rst_in;
    assign addr_op        = addr_out_reg;
    assign wr_data_op     = wr_data_reg;
    assign led_op         = led_reg;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller that sits between the UART receiver (byte + one-cycle valid strobe) and the board's register/LED resources.
- Assembles fixed 5-byte command frames, checks them, and executes the command: register write, register read, or LED set.
- Sequences a reply over a valid/ready byte handshake to a UART transmitter.
- Aborts partial frames on inter-byte timeout.

Parameters:
- TIMEOUT_CLKS, 17360, max idle clocks between bytes inside a frame (2 byte-times at 115200 baud / 100 MHz)
- SYNC_BYTE, 8'hA5, command frame start marker
- RSP_BYTE, 8'h5A, read-response start marker
- ACK_BYTE, 8'h06, reply for successful write/LED command
- NAK_BYTE, 8'h15, reply for bad checksum or unknown opcode

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- rx_datav_in  input  1  one-cycle strobe: rx_byte_in valid
- rx_byte_in  input  8  received byte
- wr_en_op  output  1  one-cycle register write strobe
- rd_en_op  output  1  one-cycle register read strobe
- addr_op  output  8  register address for wr/rd
- wr_data_op  output  8  write data
- rd_data_in  input  8  read data, valid the cycle after rd_en_op
- tx_valid_op  output  1  reply byte valid
- tx_byte_op  output  8  reply byte
- tx_ready_in  input  1  transmitter accepts byte
- led_op  output  1  LED state
- err_timeout_op  output  1  one-cycle pulse: frame aborted by timeout
- err_overrun_op  output  1  one-cycle pulse: byte dropped while replying

Behaviour:
- Reset values:
  - All outputs 0; addr_op, wr_data_op, tx_byte_op = 8'h00.
  - State IDLE; timeout counter 0.
  - Reset mid-frame or mid-reply discards everything; tx_valid_op drops the same cycle reset is sampled.
- Frame format: SYNC, OPC, ADDR, DATA, CHK, where CHK = OPC ^ ADDR ^ DATA.
- Opcodes:
  - 8'h01 = write.
  - 8'h02 = read.
  - 8'h03 = LED; led_op <= DATA[0], ADDR ignored.
  - Any other value = unknown.
- States: IDLE, GET_OPC, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, TX_0, TX_1, TX_2, TX_3.
- IDLE: on rx_datav_in with byte == SYNC_BYTE -> GET_OPC. Other bytes are ignored silently (sync hunting, no error).
- GET_OPC / GET_ADDR / GET_DATA / GET_CHK: each rx_datav_in latches the byte and advances. A second SYNC_BYTE inside a frame is treated as data, not a resync.
- Timeout:
  - Counter clears on every rx_datav_in and in IDLE; it increments only in the GET_* states.
  - When the counter reaches TIMEOUT_CLKS -> err_timeout_op pulse, go to IDLE, no execution, no reply.
  - A byte arriving on the same cycle the counter reaches TIMEOUT_CLKS wins: it is accepted and no timeout fires.
- EXEC (one cycle after the CHK byte):
  - Checksum bad, or opcode unknown: reply NAK_BYTE; no strobes, LED unchanged.
  - Write: wr_en_op = 1 for this cycle with addr_op/wr_data_op valid; reply ACK_BYTE.
  - LED: update led_op; reply ACK_BYTE.
  - Read: rd_en_op = 1 with addr_op valid -> RD_WAIT.
- RD_WAIT: capture rd_data_in (registered-bank latency of exactly 1 cycle). Reply is RSP_BYTE, ADDR, rd_data, ADDR ^ rd_data.
- TX_n:
  - tx_valid_op high, tx_byte_op stable until tx_valid_op & tx_ready_in; a byte transfers on that cycle.
  - The next byte is presented the following cycle with no gap. After the last byte -> IDLE.
  - Single-byte replies (ACK/NAK) use TX_0 only.
- Latency: tx_valid_op rises 1 cycle after CHK strobe (ACK/NAK) or 2 cycles (read response), given tx_ready_in high.
- rx_datav_in during EXEC/RD_WAIT/TX_*: byte dropped, err_overrun_op pulses that cycle, state unaffected.
- addr_op and wr_data_op hold their last values between commands; rd_en_op and wr_en_op are never both high.

Decomposition:
- Shared package uart_pkg:
  - state typedef/encoding
  - opcode constants (OPC_WR, OPC_RD, OPC_LED)
  - SYNC/RSP/ACK/NAK byte constants
  - CLKS_PER_BIT = 868
- One natural sub-module: uart_cmd_timeout (loadable inter-byte timeout counter with clear/enable/expired outputs).
- Reply byte sequencing stays in the main FSM.

Test Plan:
- Write: bytes A5 01 03 7E 7C -> wr_en_op pulse with addr_op=03, wr_data_op=7E; tx sends 06; no errors.
- Read: rd_data_in=7E for addr 03, bytes A5 02 03 00 01 -> rd_en_op pulse; tx sends 5A 03 7E 7D in order.
  - Hold tx_ready_in low 50 cycles before 2nd byte -> tx_byte_op stable at 03 throughout.
- Bad checksum A5 01 03 7E 00 -> no wr_en_op; tx 15.
- Then LED frame A5 03 00 01 02 -> led_op=1, tx 06.
- Then A5 03 00 00 03 -> led_op=0.
- Timeout: A5 01, then silence TIMEOUT_CLKS cycles -> err_timeout_op single pulse, no strobes.
  - Next valid write frame executes normally.
- Hunting/overrun/reset:
  - Bytes 00 FF before a frame -> ignored.
  - Extra byte injected during tx reply -> err_overrun_op pulse, reply unchanged.
  - rst_in asserted after A5 01 03 -> all outputs 0; next full frame accepted.
